// File: rtl/priority_encoder83_ls148_pkg.sv
// Shared constants and the output bundle type for the 74LS148-style 8-to-3 priority encoder.
package priority_encoder83_ls148_pkg;

  localparam int NUM_LINES = 8;
  localparam int IDX_W     = 3;

  localparam logic [IDX_W-1:0] IDLE_A_N = 3'b111;

  typedef struct packed {
    logic [IDX_W-1:0] a_n;
    logic             gs_n;
    logic             eo_n;
  } ls148_out_t;

  localparam ls148_out_t DISABLED_OUT = '{a_n: IDLE_A_N, gs_n: 1'b1, eo_n: 1'b1};

endpackage

// File: rtl/priority_encoder83_ls148_ls148_core.sv
// Purely combinational 74LS148 function: the highest-index active-low request wins.
module ls148_core
  import priority_encoder83_ls148_pkg::*;
(
  input  logic                 ei_n_i,
  input  logic [NUM_LINES-1:0] in_n_i,
  output logic [IDX_W-1:0]     a_n_o,
  output logic                 gs_n_o,
  output logic                 eo_n_o
);

  logic [IDX_W-1:0] idx;
  logic             any_req;

  always_comb begin
    idx     = '0;
    any_req = 1'b1;
    casez (in_n_i)
      8'b0???????: idx = 3'd7;
      8'b10??????: idx = 3'd6;
      8'b110?????: idx = 3'd5;
      8'b1110????: idx = 3'd4;
      8'b11110???: idx = 3'd3;
      8'b111110??: idx = 3'd2;
      8'b1111110?: idx = 3'd1;
      8'b11111110: idx = 3'd0;
      default:     any_req = 1'b0;
    endcase
  end

  always_comb begin
    a_n_o  = IDLE_A_N;
    gs_n_o = 1'b1;
    eo_n_o = 1'b1;
    if (!ei_n_i) begin
      if (any_req) begin
        a_n_o  = ~idx;
        gs_n_o = 1'b0;
      end else begin
        // Enabled with nothing pending: hand priority down the cascade.
        eo_n_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/priority_encoder83_ls148.sv
// Cascadable 8-to-3 priority encoder, optionally registered with synchronous reset.
module priority_encoder83_ls148
  import priority_encoder83_ls148_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ei_n,
  input  logic [NUM_LINES-1:0] in_n,
  output logic [IDX_W-1:0]     a_n,
  output logic                 gs_n,
  output logic                 eo_n
);

  ls148_out_t out_d;

  ls148_core u_core (
    .ei_n_i (ei_n),
    .in_n_i (in_n),
    .a_n_o  (out_d.a_n),
    .gs_n_o (out_d.gs_n),
    .eo_n_o (out_d.eo_n)
  );

  if (REG_OUT) begin : g_reg
    ls148_out_t out_q;

    always_ff @(posedge clk) begin
      if (rst) out_q <= DISABLED_OUT;
      else     out_q <= out_d;
    end

    assign a_n  = out_q.a_n;
    assign gs_n = out_q.gs_n;
    assign eo_n = out_q.eo_n;
  end else begin : g_comb
    assign a_n  = out_d.a_n;
    assign gs_n = out_d.gs_n;
    assign eo_n = out_d.eo_n;
  end

endmodule

// File: tb/tb_priority_encoder83_ls148.sv
// Directed and exhaustive checks of the registered and combinational encoder variants.
module tb_priority_encoder83_ls148;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ei_n = 1'b1;
  logic [7:0] in_n = 8'hFF;

  logic [2:0] a_n_r, a_n_c;
  logic       gs_n_r, gs_n_c, eo_n_r, eo_n_c;

  int errors = 0;
  int checks = 0;

  logic [2:0] pa;
  logic       pgs, peo;
  bit         pvalid = 1'b0;

  always #5 clk = ~clk;

  priority_encoder83_ls148 #(.REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst(rst), .ei_n(ei_n), .in_n(in_n),
    .a_n(a_n_r), .gs_n(gs_n_r), .eo_n(eo_n_r)
  );

  priority_encoder83_ls148 #(.REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst(rst), .ei_n(ei_n), .in_n(in_n),
    .a_n(a_n_c), .gs_n(gs_n_c), .eo_n(eo_n_c)
  );

  // Independent reference: scan from line 7 downward, first low line wins.
  task automatic ref_f(input logic ei, input logic [7:0] in, output logic [2:0] ea,
                       output logic egs, output logic eeo);
    bit found;
    found = 1'b0;
    ea = 3'b111; egs = 1'b1; eeo = 1'b1;
    if (!ei) begin
      for (int k = 7; k >= 0; k--) begin
        if (!found && !in[k]) begin
          found = 1'b1;
          ea    = ~3'(k);
        end
      end
      egs = ~found;
      eeo = found;
    end
  endtask

  task automatic check3(input string tag, input logic [2:0] oa, input logic ogs, input logic oeo,
                        input logic [2:0] ea, input logic egs, input logic eeo);
    logic [4:0] obs, exp;
    obs = {oa, ogs, oeo};
    exp = {ea, egs, eeo};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got a_n/gs_n/eo_n=%b/%b/%b exp=%b/%b/%b", tag, oa, ogs, oeo, ea, egs, eeo);
    end
    checks++;
    assert ((ogs | oeo) === 1'b1) else begin
      errors++;
      $error("FAIL %s_gs_eo_both_low got gs_n=%b eo_n=%b exp not both 0", tag, ogs, oeo);
    end
  endtask

  // One cycle: check the registered result of the previous step, then drive this step
  // and check the combinational variant immediately.
  task automatic apply(input logic r, input logic ei, input logic [7:0] in,
                       input logic [2:0] ea, input logic egs, input logic eeo, input string tag);
    @(negedge clk);
    if (pvalid) check3({"reg_", tag}, a_n_r, gs_n_r, eo_n_r, pa, pgs, peo);
    rst  = r;
    ei_n = ei;
    in_n = in;
    #1;
    check3({"comb_", tag}, a_n_c, gs_n_c, eo_n_c, ea, egs, eeo);
    if (r) begin pa = 3'b111; pgs = 1'b1; peo = 1'b1; end
    else   begin pa = ea;     pgs = egs;  peo = eeo;  end
    pvalid = 1'b1;
  endtask

  logic [7:0] line7 [8] = '{8'h00, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
  logic [2:0] walk_a [8] = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};

  initial begin
    logic [2:0] ea;
    logic       egs, eeo;
    logic [8:0] v;

    // Reset for two cycles with inputs that would otherwise produce an active result.
    apply(1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1, "rst0");
    apply(1'b1, 1'b0, 8'h7F, 3'b000, 1'b0, 1'b1, "rst1");
    apply(1'b0, 1'b0, 8'hEF, 3'b011, 1'b0, 1'b1, "post_rst");

    apply(1'b0, 1'b1, 8'h00, 3'b111, 1'b1, 1'b1, "disabled");
    apply(1'b0, 1'b0, 8'hFF, 3'b111, 1'b1, 1'b0, "idle");

    for (int i = 0; i < 8; i++)
      apply(1'b0, 1'b0, line7[i], 3'b000, 1'b0, 1'b1, $sformatf("line7_%0d", i));

    for (int k = 0; k < 8; k++)
      apply(1'b0, 1'b0, ~(8'h01 << k), walk_a[k], 1'b0, 1'b1, $sformatf("walk_%0d", k));

    apply(1'b0, 1'b0, 8'b1111_0110, 3'b100, 1'b0, 1'b1, "multi_3");

    // Mid-stream reset discards the result of the vector sampled with rst high.
    apply(1'b0, 1'b0, 8'hFB, 3'b101, 1'b0, 1'b1, "pre_midrst");
    apply(1'b1, 1'b0, 8'hDF, 3'b010, 1'b0, 1'b1, "midrst");
    apply(1'b0, 1'b1, 8'hFF, 3'b111, 1'b1, 1'b1, "after_midrst");

    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      ref_f(v[8], v[7:0], ea, egs, eeo);
      apply(1'b0, v[8], v[7:0], ea, egs, eeo, $sformatf("exh_%0d", i));
    end

    // Flush the last registered result.
    @(negedge clk);
    check3("reg_flush", a_n_r, gs_n_r, eo_n_r, pa, pgs, peo);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder83_ls148.md
Name: priority_encoder83_ls148

Overview:
- 8-line to 3-line priority encoder with 74LS148 semantics.
- All inputs and outputs are active-low.
- The input with the highest index that is asserted (low) wins; its index is output inverted.
- Outputs are registered in the system clock domain. Used as a cascadable priority stage: a lower-priority stage's ei_n takes this block's eo_n.

Parameters:
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs combinational (clk/rst unused for data path).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ei_n  input  1  enable input, active-low; 1 = block disabled.
- in_n  input  8  request lines, active-low; in_n[7] highest priority, in_n[0] lowest.
- a_n  output  3  encoded index of highest-priority active request, inverted (a_n = ~index).
- gs_n  output  1  group select, active-low; 0 when enabled and at least one request active.
- eo_n  output  1  enable output, active-low; 0 when enabled and no request active (cascade to next stage's ei_n).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Combinational function f(ei_n, in_n):
  - ei_n=1: a_n=3'b111, gs_n=1, eo_n=1; in_n ignored.
  - ei_n=0 and in_n=8'hFF: a_n=3'b111, gs_n=1, eo_n=0.
  - ei_n=0 and any in_n bit low: k = highest index with in_n[k]=0; a_n=~k (3 bits), gs_n=0, eo_n=1. Lower-index bits are don't-care.
  - gs_n and eo_n are never both 0. Both are 1 only when disabled.
- REG_OUT=1:
  - Outputs take f(inputs sampled at clock edge N) after edge N.
  - Latency is exactly 1 cycle; no handshake; new input accepted every cycle.
- Reset (REG_OUT=1):
  - While rst=1 at a rising edge, outputs load the disabled state: a_n=3'b111, gs_n=1, eo_n=1.
  - Reset has priority over input sampling.
  - Deasserting reset resumes normal sampling at the next edge.
  - A reset mid-stream discards the in-flight result.
- Power-up before the first reset: outputs undefined.
- REG_OUT=0: outputs equal f(inputs) continuously; rst has no effect.
- X/Z on inputs need not be handled.

Decomposition:
- Shared package holds:
  - constant IDLE_A_N = 3'b111
  - constant NUM_LINES = 8
  - constant IDX_W = 3
- One natural sub-module, ls148_core: purely combinational f(ei_n, in_n) -> (a_n, gs_n, eo_n).
- The top level wraps ls148_core with the optional output register and synchronous reset.
- Implement the priority with a descending-index loop or casez. Do not use an explicit 256-entry table.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> a_n=111, gs_n=1, eo_n=1; after release, outputs follow inputs 1 cycle later.
- Disabled: ei_n=1, in_n=8'h00 -> a_n=111, gs_n=1, eo_n=1.
- Enabled, idle: ei_n=0, in_n=8'hFF -> a_n=111, gs_n=1, eo_n=0.
- Priority to line 7: ei_n=0, in_n in {8'h00, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01}, applied on consecutive cycles -> each result a_n=000, gs_n=0, eo_n=1, one cycle after its input.
- Walking single request: ei_n=0, in_n=~(1<<k) for k=0..7 -> a_n=~k (k=0 gives 111, k=5 gives 010), gs_n=0, eo_n=1. Also in_n=8'b1111_0110 -> a_n=~3=100.
- Exhaustive check: all 512 (ei_n, in_n) combinations compared against a reference model at 1-cycle latency. Repeat with REG_OUT=0 at zero latency. Assert gs_n and eo_n are never both low.
